// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_mult_pkg;

  // Controller states: waiting for a request, or stepping through the bits
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  // Step counter width: must be able to hold the value WIDTH itself
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_abs.sv
// Magnitude and sign extraction for one two's complement operand.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
module seq_mult_abs #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_val,
  output logic [WIDTH-1:0] o_mag,
  output logic             o_sgn
);

  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned
  assign o_sgn = i_val[WIDTH-1];
  assign o_mag = o_sgn ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, 2*WIDTH-bit product; optional two's complement mode via SEQ_MULT_SIGNED_EN.
// Latency: done/product appear WIDTH+1 cycles after the start cycle; one result per WIDTH+1 cycles back-to-back.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);
  // The counter holds the number of steps already taken; this value marks the final one
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t            r_state;
  logic [PW-1:0]     r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [PW-1:0]     r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [PW-1:0]     r_product;

  logic [WIDTH-1:0]  w_a_mag;
  logic [WIDTH-1:0]  w_b_mag;
  logic [PW-1:0]     w_addend;
  logic [PW-1:0]     w_acc_next;
  logic [PW-1:0]     w_result;
  logic              w_last;

`ifdef SEQ_MULT_SIGNED_EN
  logic              r_neg;
  logic              w_a_sgn;
  logic              w_b_sgn;
  logic              w_neg;

  // Operands are multiplied as magnitudes; the sign is reapplied at the end
  seq_mult_abs #(.WIDTH(WIDTH)) u_abs_a (
    .i_val (a),
    .o_mag (w_a_mag),
    .o_sgn (w_a_sgn)
  );

  seq_mult_abs #(.WIDTH(WIDTH)) u_abs_b (
    .i_val (b),
    .o_mag (w_b_mag),
    .o_sgn (w_b_sgn)
  );

  assign w_neg    = w_a_sgn ^ w_b_sgn;
  assign w_result = r_neg ? (~w_acc_next + PW'(1)) : w_acc_next;
`else
  assign w_a_mag  = a;
  assign w_b_mag  = b;
  assign w_result = w_acc_next;
`endif

  // One shift-add step: add the shifted multiplicand when the multiplier LSB is set
  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;
  assign w_last     = (r_cnt == LAST_STEP);

  // Controller and datapath: accept in IDLE, step WIDTH times in CALC, publish on the last step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      r_neg     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
`ifdef SEQ_MULT_SIGNED_EN
            r_neg    <= w_neg;
`endif
          end
        end
        CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            // busy drops together with done so a start in the done cycle is taken
            r_product <= w_result;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier at WIDTH=2, 8 and 16; checks the signed build when SEQ_MULT_SIGNED_EN is defined.
// Latency: expects done WIDTH+1 cycles after each start cycle.
// Backpressure: exercises start-while-busy and start in the done cycle.
module tb_seq_multiplier;

  logic clk;
  logic rst;

  logic        start_v [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [31:0] prod_v  [3];

  logic [1:0]  a2, b2;
  logic [3:0]  p2;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic        busy2, done2, busy8, done8, busy16, done16;

  int n_chk;
  int n_pass;

  logic [15:0] qa [$];
  logic [15:0] qb [$];

  assign a2  = a_v[0][1:0];
  assign b2  = b_v[0][1:0];
  assign a8  = a_v[1][7:0];
  assign b8  = b_v[1][7:0];
  assign a16 = a_v[2];
  assign b16 = b_v[2];

  assign busy_v[0] = busy2;
  assign busy_v[1] = busy8;
  assign busy_v[2] = busy16;
  assign done_v[0] = done2;
  assign done_v[1] = done8;
  assign done_v[2] = done16;
  assign prod_v[0] = {28'd0, p2};
  assign prod_v[1] = {16'd0, p8};
  assign prod_v[2] = p16;

  seq_multiplier #(.WIDTH(2)) u_dut2 (
    .clk (clk), .rst (rst), .start (start_v[0]), .a (a2), .b (b2),
    .busy (busy2), .done (done2), .product (p2)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk (clk), .rst (rst), .start (start_v[1]), .a (a8), .b (b8),
    .busy (busy8), .done (done8), .product (p8)
  );

  seq_multiplier #(.WIDTH(16)) u_dut16 (
    .clk (clk), .rst (rst), .start (start_v[2]), .a (a16), .b (b16),
    .busy (busy16), .done (done16), .product (p16)
  );

  always #5 clk = ~clk;

  function automatic int wid(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 8 : 16);
  endfunction

  // Reference product truncated to 2*w bits, using native multiplication
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b);
    longint mask1, mask2, sa, sb, p;
    mask1 = (longint'(1) << w) - 1;
    mask2 = (longint'(1) << (2 * w)) - 1;
    sa = longint'(a) & mask1;
    sb = longint'(b) & mask1;
`ifdef SEQ_MULT_SIGNED_EN
    if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
    if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
`endif
    p = sa * sb;
    return 32'(p & mask2);
  endfunction

  task automatic issue(input int i, input logic [15:0] a, input logic [15:0] b);
    a_v[i]     = a;
    b_v[i]     = b;
    start_v[i] = 1'b1;
  endtask

  // Single multiply with an observation window well past the expected done
  task automatic run_one(input int i, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] prod, output int lat, output int ndone);
    int w;
    w = wid(i);
    lat = -1;
    ndone = 0;
    @(negedge clk);
    issue(i, a, b);
    for (int c = 1; c <= 2 * w + 4; c++) begin
      @(posedge clk);
      #1 start_v[i] = 1'b0;
      @(negedge clk);
      if (done_v[i]) begin
        ndone++;
        if (lat < 0) lat = c;
      end
    end
    prod = prod_v[i];
  endtask

  // Back-to-back stream from qa/qb; each next start is raised in the done cycle
  task automatic run_stream(input int i);
    int w, k, cnt, n;
    logic [31:0] exp_p;
    w = wid(i);
    k = 0;
    cnt = 0;
    n = qa.size();
    @(negedge clk);
    issue(i, qa[0], qb[0]);
    while (k < n) begin
      @(posedge clk);
      #1 start_v[i] = 1'b0;
      @(negedge clk);
      cnt++;
      if (done_v[i]) begin
        exp_p = ref_mul(w, qa[k], qb[k]);
        n_chk++;
        if (prod_v[i] !== exp_p)
          $display("FAIL stream_w%0d_prod[%0d] %h*%h got %h want %h", w, k, qa[k], qb[k], prod_v[i], exp_p);
        else n_pass++;
        n_chk++;
        if (cnt !== w + 1)
          $display("FAIL stream_w%0d_latency[%0d] got %0d want %0d", w, k, cnt, w + 1);
        else n_pass++;
        k++;
        cnt = 0;
        if (k < n) issue(i, qa[k], qb[k]);
      end else if (cnt > w + 3) begin
        n_chk++;
        $display("FAIL stream_w%0d_timeout[%0d] got no done after %0d cycles want %0d", w, k, cnt, w + 1);
        k = n;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (busy_v[i] !== 1'b0) $display("FAIL reset_busy[%0d] got %b want 0", i, busy_v[i]);
      else n_pass++;
      n_chk++;
      if (done_v[i] !== 1'b0) $display("FAIL reset_done[%0d] got %b want 0", i, done_v[i]);
      else n_pass++;
      n_chk++;
      if (prod_v[i] !== 32'd0) $display("FAIL reset_product[%0d] got %h want 0", i, prod_v[i]);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_exhaustive_w2();
    qa.delete();
    qb.delete();
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) begin
        qa.push_back(16'(x));
        qb.push_back(16'(y));
      end
    run_stream(0);
  endtask

  task automatic test_corners_w8();
    logic [31:0] p;
    int lat, nd;
    run_one(1, 16'h00FF, 16'h00FF, p, lat, nd);
`ifdef SEQ_MULT_SIGNED_EN
    n_chk++;
    if (p !== 32'h0000_0001) $display("FAIL corner_ffxff got %h want 00000001", p);
    else n_pass++;
`else
    n_chk++;
    if (p !== 32'h0000_FE01) $display("FAIL corner_ffxff got %h want 0000fe01", p);
    else n_pass++;
`endif
    n_chk++;
    if (lat !== 9) $display("FAIL corner_ffxff_latency got %0d want 9", lat);
    else n_pass++;
    n_chk++;
    if (nd !== 1) $display("FAIL corner_ffxff_done_count got %0d want 1", nd);
    else n_pass++;

    run_one(1, 16'h0000, 16'h00A5, p, lat, nd);
    n_chk++;
    if (p !== 32'h0000_0000) $display("FAIL corner_00xa5 got %h want 00000000", p);
    else n_pass++;
    n_chk++;
    if (lat !== 9) $display("FAIL corner_00xa5_latency got %0d want 9", lat);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int nd, nb, lat;
    nd = 0;
    nb = 0;
    lat = -1;
    @(negedge clk);
    issue(1, 16'h0012, 16'h0034);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1 start_v[1] = 1'b0;
      @(negedge clk);
      if (busy_v[1]) nb++;
      if (done_v[1]) begin
        nd++;
        if (lat < 0) lat = c;
      end
      if (c == 2) issue(1, 16'h00FF, 16'h00FF);
    end
    n_chk++;
    if (nd !== 1) $display("FAIL busy_start_done_count got %0d want 1", nd);
    else n_pass++;
    n_chk++;
    if (prod_v[1] !== 32'h0000_03A8) $display("FAIL busy_start_product got %h want 000003a8", prod_v[1]);
    else n_pass++;
    n_chk++;
    if (nb !== 8) $display("FAIL busy_start_busy_cycles got %0d want 8", nb);
    else n_pass++;
    n_chk++;
    if (lat !== 9) $display("FAIL busy_start_latency got %0d want 9", lat);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] p;
    int lat, nd;
    @(negedge clk);
    issue(1, 16'h000F, 16'h000F);
    repeat (3) begin
      @(posedge clk);
      #1 start_v[1] = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy_v[1] !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy_v[1]);
    else n_pass++;
    n_chk++;
    if (prod_v[1] !== 32'd0) $display("FAIL midrst_product got %h want 0", prod_v[1]);
    else n_pass++;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[1]) nd++;
    end
    n_chk++;
    if (nd !== 0) $display("FAIL midrst_spurious_done got %0d want 0", nd);
    else n_pass++;

    run_one(1, 16'h0002, 16'h0003, p, lat, nd);
    n_chk++;
    if (p !== 32'h0000_0006) $display("FAIL midrst_next_product got %h want 00000006", p);
    else n_pass++;
    n_chk++;
    if (lat !== 9) $display("FAIL midrst_next_latency got %0d want 9", lat);
    else n_pass++;
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic test_signed_w8();
    logic [31:0] p;
    int lat, nd;
    run_one(1, 16'h00FD, 16'h0005, p, lat, nd);
    n_chk++;
    if (p !== 32'h0000_FFF1) $display("FAIL signed_m3x5 got %h want 0000fff1", p);
    else n_pass++;
    n_chk++;
    if (lat !== 9) $display("FAIL signed_m3x5_latency got %0d want 9", lat);
    else n_pass++;
    run_one(1, 16'h0080, 16'h0080, p, lat, nd);
    n_chk++;
    if (p !== 32'h0000_4000) $display("FAIL signed_m128xm128 got %h want 00004000", p);
    else n_pass++;
    n_chk++;
    if (lat !== 9) $display("FAIL signed_m128xm128_latency got %0d want 9", lat);
    else n_pass++;
    run_one(1, 16'h007F, 16'h0080, p, lat, nd);
    n_chk++;
    if (p !== 32'h0000_C080) $display("FAIL signed_127xm128 got %h want 0000c080", p);
    else n_pass++;
    n_chk++;
    if (lat !== 9) $display("FAIL signed_127xm128_latency got %0d want 9", lat);
    else n_pass++;
  endtask
`endif

  task automatic test_random_w16();
    qa.delete();
    qb.delete();
    qa.push_back(16'hFFFF);
    qb.push_back(16'hFFFF);
    qa.push_back(16'h8000);
    qb.push_back(16'h0001);
    for (int k = 0; k < 20; k++) begin
      qa.push_back(16'($urandom));
      qb.push_back(16'($urandom));
    end
    run_stream(2);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_chk = 0;
    n_pass = 0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      a_v[i]     = 16'd0;
      b_v[i]     = 16'd0;
    end
    test_reset();
    test_exhaustive_w2();
    test_corners_w8();
    test_start_while_busy();
    test_reset_mid_op();
`ifdef SEQ_MULT_SIGNED_EN
    test_signed_w8();
`endif
    test_random_w16();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier producing a full-width `2*WIDTH` product from two `WIDTH`-bit operands. It is the multi-cycle successor to our combinational 2-bit multiplier, with a start/done handshake and an optional signed mode. It sits as a shared arithmetic unit behind controllers that trade latency for area.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range 2..32.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous reset, active-high.
- `start` input 1: request a multiply; sampled only while `busy`=0.
- `a` input `WIDTH`: multiplicand; latched on the accepting edge.
- `b` input `WIDTH`: multiplier; latched on the accepting edge.
- `busy` output 1: high while a multiply is in progress.
- `done` output 1: single-cycle pulse when `product` is updated.
- `product` output `2*WIDTH`: result; holds its value until the next `done`.

## Operation
- States:
  - IDLE: accepts `start`, latches `a` and `b`, clears the accumulator and count, goes to CALC.
  - CALC: performs one shift-add step per cycle.
- Each CALC step:
  - If the multiplier LSB is 1, add the shifted multiplicand into the `2*WIDTH`-bit accumulator.
  - Shift the multiplier right and the multiplicand left.
  - Increment the count, which is `$clog2(WIDTH+1)` bits wide.
- After exactly `WIDTH` CALC steps:
  - Write the accumulator to `product`.
  - Assert `done` for one cycle.
  - Return to IDLE.
- `busy` is high in CALC only.
- `start` asserted while `busy`=1 is ignored. Operands are not re-latched and the result is unaffected.
- `a`/`b` may change freely after the accepting edge.
- Arithmetic is unsigned and exact. No overflow is possible: the maximum result `(2^W-1)^2` fits in `2*WIDTH` bits.
- Operand 0 (either input) still takes the full latency and produces 0.
- Reset values: `busy`=0, `done`=0, `product`=0, state=IDLE.
- `rst` mid-operation aborts the multiply. No `done` is produced and `product` reads 0.

## Timing
- `start` sampled at edge E0 → `busy` high from E0 to E_W.
- `done`=1 and the new `product` are visible in the cycle after edge E_W, i.e. `WIDTH`+1 cycles after the start cycle.
- `busy` is already 0 in the `done` cycle. A `start` in that same cycle is accepted, so the back-to-back throughput is one result per `WIDTH`+1 cycles.
- `done` is never high for two consecutive cycles unless `WIDTH`+1 = 1, which is illegal.
- `rst` has priority over `start` in the same cycle.

## Configuration
- Macro: `SEQ_MULT_SIGNED_EN`.
- **Defined:**
  - `a`, `b` and `product` are two's complement.
  - At acceptance, magnitudes are latched (`WIDTH` bits unsigned, so -2^(W-1) is represented exactly) and the result sign is recorded as `a[MSB]^b[MSB]`.
  - On the final step, the accumulator is conditionally negated before being written to `product`.
  - Latency and handshake are identical to the unsigned build.
- **Undefined:** operands are unsigned, and the sign/negation logic is absent.

## Structure
- Package `seq_mult_pkg` holds:
  - the state enum typedef (IDLE, CALC);
  - a `cnt_width(WIDTH)` constant function.
- One natural sub-module, `seq_mult_abs`:
  - combinational magnitude and sign extraction for one operand;
  - instantiated twice, only under `SEQ_MULT_SIGNED_EN`.
- Otherwise a single module.

## Test plan
- **WIDTH=2, exhaustive:** all 16 `{a,b}` pairs run back-to-back. Each `product` equals `a*b` (e.g. 3×3 → 9), and `done` arrives 3 cycles after each `start`.
- **WIDTH=8 corner values:** 0xFF×0xFF → `product`=0xFE01 with `done` in cycle 9; 0x00×0xA5 → 0x0000, also in cycle 9.
- **Start while busy:** start 0x12×0x34, then pulse `start` with 0xFF×0xFF in cycle 3. Exactly one `done`, `product`=0x03A8, and `busy` does not re-extend.
- **Reset mid-operation:** assert `rst` in cycle 4 of 0x0F×0x0F. `busy`=0, `product`=0, and no `done`; the next start of 2×3 gives 0x0006.
- **Signed build, WIDTH=8:**
  - -3×5 → 0xFFF1;
  - -128×-128 → 0x4000;
  - 127×-128 → 0xC080;
  - all with latency 9.
- **Randomised stream, WIDTH=16:** start issued in every `done` cycle. Results match the reference model, with one result every 17 cycles.
